jam: RTL and testbench
======================

Name: jam

Overview:
- Exhaustive job-assignment solver: 8 workers, 8 jobs, one job per worker.
- Reads a 7-bit cost table from an external combinational cost ROM addressed by (W, J).
- Enumerates all 8! = 40320 permutations and reports the minimum total cost and how many permutations achieve it.
- Standalone compute block; the ROM sits outside the block and returns Cost in the same cycle that W/J are presented.

Parameters:
- N, 8, number of workers and jobs (fixed; port widths assume 8).
- CW, 7, cost word width.
- SW, 10, internal sum width; holds 8*127 = 1016 without overflow.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous active-low reset (0 = reset), sampled on the CLK rising edge.
- W  output  3  worker index to the cost ROM; registered.
- J  output  3  job index to the cost ROM; registered.
- Cost  input  7  cost[W][J], combinational from the ROM; valid in the same cycle W/J are driven.
- MatchCount  output  4  number of permutations whose total equals MinCost; saturates at 15.
- MinCost  output  9  minimum total cost; low 9 bits of the internal 10-bit minimum.
- Valid  output  1  result-ready flag.

Behaviour:
- Reset (RST=0 at a clock edge):
  - W=0, J=0, Valid=0, MinCost=0, MatchCount=0.
  - perm[0..7] = 0..7; accumulator = 0; state = INIT.
  - Reset asserted mid-run aborts the run and restarts from INIT on the first clock edge with RST=1.
- Outputs are meaningful only while Valid=1.
- FSM states: INIT, ACC, CMP, NEXT, DONE.
- INIT: first_flag=1, drive W=0 / J=perm[0], go to ACC.
- ACC: 8 cycles, one per worker.
  - Cycle k drives W=k, J=perm[k].
  - Cost is sampled at the end of that cycle; sum += Cost.
  - After k=7, go to CMP.
- CMP (one cycle):
  - If first_flag or sum < best: best = sum, MatchCount = 1, first_flag = 0.
  - Else if sum == best: MatchCount++, saturating at 15.
  - Clear sum.
  - If perm = 7,6,5,4,3,2,1,0 (last lexicographic permutation), go to DONE; else go to NEXT.
- NEXT: lexicographic next-permutation.
  - Find the largest i with perm[i] < perm[i+1].
  - Find the largest j > i with perm[j] > perm[i].
  - Swap perm[i] and perm[j], then reverse perm[i+1..7].
  - Multi-cycle sequential or single-cycle combinational implementation is allowed; total run must finish within 1,000,000 cycles after reset release.
  - Return to ACC with W=0.
- DONE:
  - Valid=1; MinCost = best[8:0]; MatchCount holds its final value.
  - Outputs and Valid stay constant until reset.
  - W and J hold their last values.
- Invariants:
  - W and J are always in 0..7.
  - Every permutation is visited exactly once, starting from identity 0..7.
  - Starting from identity, the last-permutation check covers all 40320 permutations.
- Arithmetic:
  - Unsigned.
  - Comparisons use the full 10-bit sum.
  - MinCost truncates to 9 bits; the cost table keeps the true minimum ≤ 511.

Test Plan:
- Diagonal table (cost[w][w]=0, all others 50) -> Valid asserts, MinCost=0, MatchCount=1, within 1e6 cycles.
- Diagonal zeros plus cost[0][1]=cost[1][0]=0, all others 100 -> MinCost=0, MatchCount=2.
- Anti-diagonal table (cost[w][7-w]=3, all others 127) -> MinCost=24, MatchCount=1.
- All entries 5 -> MinCost=40, MatchCount saturates at 15 (40320 ties).
- Reset mid-run: drive RST=0 for 2 cycles about 1000 cycles after start, using the diagonal table -> W=J=0 and Valid=0 during reset; the run restarts and ends with MinCost=0, MatchCount=1.
- Throughout every run -> W,J < 8 on every cycle; Valid stays 0 until completion, then stays 1 with MinCost and MatchCount stable for 10 or more cycles.

Source files
------------

// File: rtl/jam.sv
// jam: exhaustive 8x8 job-assignment solver.
//
// Walks every permutation of jobs over workers in lexicographic order,
// starting from the identity 0..7. For each permutation it reads the eight
// costs from an external combinational cost ROM and adds them up. It keeps
// the smallest total seen and counts how many permutations reach it.
//
// Ports:
//   CLK         clock; all state changes on the rising edge
//   RST         synchronous active-low reset (0 = reset)
//   W, J        registered worker / job address to the cost ROM
//   Cost        cost[W][J], returned by the ROM in the same cycle
//   MatchCount  number of permutations hitting the minimum, saturating at 15
//   MinCost     minimum total cost (low 9 bits of the internal sum)
//   Valid       high once the search is complete; results hold until reset
module jam #(
  parameter int N  = 8,
  parameter int CW = 7,
  parameter int SW = 10
) (
  input  logic          CLK,
  input  logic          RST,
  output logic [2:0]    W,
  output logic [2:0]    J,
  input  logic [CW-1:0] Cost,
  output logic [3:0]    MatchCount,
  output logic [8:0]    MinCost,
  output logic          Valid
);

  typedef enum logic [2:0] {INIT, ACC, CMP, NEXT, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [2:0]    perm      [N];
  logic [2:0]    perm_next [N];
  logic [2:0]    swapped   [N];
  logic [2:0]    piv_i;
  logic [2:0]    piv_j;
  logic [2:0]    k;
  logic [SW-1:0] sum;
  logic [SW-1:0] best;
  logic [SW-1:0] best_new;
  logic          take_new;
  logic          first_flag;
  logic          is_last;

  // The descending permutation 7,6,...,0 is the final one in lexicographic
  // order, so seeing it in CMP means the search is exhausted.
  always_comb begin
    is_last = 1'b1;
    for (int m = 0; m < N; m++) begin
      if (perm[m] != 3'(N - 1 - m)) is_last = 1'b0;
    end
  end

  // Single-cycle next-permutation. piv_i is the rightmost ascent, piv_j the
  // rightmost element after it that is larger; after swapping them the tail
  // is descending, so reversing it yields the smallest successor. NEXT is
  // only entered when is_last is false, so an ascent always exists.
  always_comb begin
    piv_i = '0;
    piv_j = '0;
    for (int m = 0; m < N - 1; m++) begin
      if (perm[m] < perm[m+1]) piv_i = 3'(m);
    end
    for (int m = 1; m < N; m++) begin
      if (3'(m) > piv_i && perm[m] > perm[piv_i]) piv_j = 3'(m);
    end
    for (int m = 0; m < N; m++) swapped[m] = perm[m];
    swapped[piv_i] = perm[piv_j];
    swapped[piv_j] = perm[piv_i];
    for (int m = 0; m < N; m++) begin
      perm_next[m] = swapped[m];
      if (3'(m) > piv_i) perm_next[m] = swapped[3'(int'(piv_i) + N - m)];
    end
  end

  // The first permutation always becomes the reference minimum; after that a
  // strictly smaller total replaces it and an equal total counts as a tie.
  always_comb begin
    take_new = first_flag || (sum < best);
    best_new = take_new ? sum : best;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state <= INIT;
    else      state <= state_next;
  end

  // Next-state logic: eight ACC cycles per permutation, then one CMP and one
  // NEXT, until the last permutation has been compared.
  always_comb begin
    state_next = state;
    case (state)
      INIT: state_next = ACC;
      ACC:  if (k == 3'd7) state_next = CMP;
      CMP:  state_next = is_last ? DONE : NEXT;
      NEXT: state_next = ACC;
      DONE: state_next = DONE;
      default: state_next = INIT;
    endcase
  end

  // Datapath. W/J are registered one cycle ahead of the ACC cycle that uses
  // them, so Cost in ACC cycle k always belongs to worker k and job perm[k].
  always_ff @(posedge CLK) begin
    if (!RST) begin
      W          <= '0;
      J          <= '0;
      Valid      <= 1'b0;
      MinCost    <= '0;
      MatchCount <= '0;
      sum        <= '0;
      best       <= '0;
      first_flag <= 1'b1;
      k          <= '0;
      for (int m = 0; m < N; m++) perm[m] <= 3'(m);
    end else begin
      case (state)
        INIT: begin
          first_flag <= 1'b1;
          sum        <= '0;
          k          <= '0;
          W          <= '0;
          J          <= perm[0];
        end
        ACC: begin
          sum <= sum + SW'(Cost);
          if (k != 3'd7) begin
            k <= k + 3'd1;
            W <= k + 3'd1;
            J <= perm[k + 3'd1];
          end
        end
        CMP: begin
          sum        <= '0;
          best       <= best_new;
          first_flag <= 1'b0;
          if (take_new) begin
            MatchCount <= 4'd1;
          end else if (sum == best && MatchCount != 4'd15) begin
            MatchCount <= MatchCount + 4'd1;
          end
          if (is_last) begin
            Valid   <= 1'b1;
            MinCost <= best_new[8:0];
          end
        end
        NEXT: begin
          for (int m = 0; m < N; m++) perm[m] <= perm_next[m];
          k <= '0;
          W <= '0;
          J <= perm_next[0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jam.sv
// tb_jam: scoreboard bench for the jam assignment solver.
//
// The cost ROM is modelled as a table indexed combinationally by W/J. Each
// run loads a table, resets the block and queues the hand-computed minimum
// and tie count; a separate monitor pops that entry when Valid rises and
// also confirms the results stay frozen afterwards.
module tb_jam;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic [3:0] MatchCount;
  logic [8:0] MinCost;
  logic       Valid;

  logic [6:0] costTable [8][8];

  typedef struct packed {
    logic [8:0] minCost;
    logic [3:0] matchCount;
  } expected_t;

  expected_t scoreboard [$];

  int checks    = 0;
  int failures  = 0;
  int doneCount = 0;

  jam dut (
    .CLK        (CLK),
    .RST        (RST),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .MatchCount (MatchCount),
    .MinCost    (MinCost),
    .Valid      (Valid)
  );

  always #5 CLK = ~CLK;

  // Combinational cost ROM.
  assign Cost = costTable[W][J];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // kind 0: diagonal 0, rest 50
  // kind 1: diagonal 0 plus [0][1]=[1][0]=0, rest 100
  // kind 2: anti-diagonal 3, rest 127
  // kind 3: every entry 5
  task automatic loadTable(input int kind);
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        case (kind)
          0: costTable[w][j] = (w == j) ? 7'd0 : 7'd50;
          1: costTable[w][j] = (w == j) ? 7'd0 : 7'd100;
          2: costTable[w][j] = (j == 7 - w) ? 7'd3 : 7'd127;
          default: costTable[w][j] = 7'd5;
        endcase
      end
    end
    if (kind == 1) begin
      costTable[0][1] = 7'd0;
      costTable[1][0] = 7'd0;
    end
  endtask

  task automatic applyStimulus(input string name, input int kind,
                               input int expMin, input int expCnt,
                               input bit midReset);
    int startDone;
    bit finished;
    expected_t item;
    loadTable(kind);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput({name, " reset W"}, 32'(W), 0);
    checkOutput({name, " reset J"}, 32'(J), 0);
    checkOutput({name, " reset Valid"}, 32'(Valid), 0);
    item.minCost    = 9'(expMin);
    item.matchCount = 4'(expCnt);
    scoreboard.push_back(item);
    startDone = doneCount;
    RST = 1'b1;
    if (midReset) begin
      repeat (1000) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      checkOutput({name, " midreset W"}, 32'(W), 0);
      checkOutput({name, " midreset J"}, 32'(J), 0);
      checkOutput({name, " midreset Valid"}, 32'(Valid), 0);
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
    end
    finished = 1'b0;
    for (int c = 0; c < 1000000 && !finished; c++) begin
      @(negedge CLK);
      if (doneCount != startDone) finished = 1'b1;
    end
    checkOutput({name, " finished"}, 32'(finished), 1);
    if (!finished && scoreboard.size() > 0) void'(scoreboard.pop_front());
  endtask

  // Monitor: on each rising Valid, compare against the oldest queued
  // expectation, then require Valid/MinCost/MatchCount to hold steady.
  initial begin
    logic       prevValid;
    logic [8:0] heldMin;
    logic [3:0] heldCnt;
    bit         stable;
    expected_t  expItem;
    prevValid = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST === 1'b1 && Valid === 1'b1 && prevValid !== 1'b1) begin
        if (scoreboard.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected Valid: got 1, expected 0");
        end else begin
          expItem = scoreboard.pop_front();
          checkOutput("MinCost", 32'(MinCost), 32'(expItem.minCost));
          checkOutput("MatchCount", 32'(MatchCount), 32'(expItem.matchCount));
        end
        heldMin = MinCost;
        heldCnt = MatchCount;
        stable  = 1'b1;
        for (int c = 0; c < 12; c++) begin
          @(negedge CLK);
          if (Valid !== 1'b1 || MinCost !== heldMin || MatchCount !== heldCnt)
            stable = 1'b0;
        end
        checkOutput("result stable", 32'(stable), 1);
        prevValid = Valid;
        doneCount++;
      end else begin
        prevValid = Valid;
      end
    end
  end

  initial begin
    $display("[TB] starting jam runs");
    applyStimulus("diagonal",      0, 0,  1,  1'b0);
    applyStimulus("diag pair tie", 1, 0,  2,  1'b0);
    applyStimulus("anti-diagonal", 2, 24, 1,  1'b0);
    applyStimulus("all fives",     3, 40, 15, 1'b0);
    applyStimulus("mid reset",     0, 0,  1,  1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
